// File: rtl/gray_counter_updown.sv
// ============================================================================
// Module   : gray_counter_updown
// Brief    : Up/down counter with registered Gray and binary outputs, binary or
//            Gray load, and wrap pulse. Define GRAY_COUNTER_UPDOWN_SATURATE_EN
//            to saturate at the limits instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_counter_updown #(
  parameter int WORD_WIDTH = 0,
  // WORD_WIDTH must be overridden with a value >= 2; narrower values clamp to 2.
  localparam int c_W = (WORD_WIDTH < 2) ? 2 : WORD_WIDTH,
  parameter logic [c_W-1:0] INITIAL_COUNT = '0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           clear,
  input  logic           load,
  input  logic           load_is_gray,
  input  logic [c_W-1:0] load_value,
  input  logic           run,
  input  logic           up_down,
  output logic [c_W-1:0] gray_out,
  output logic [c_W-1:0] binary_out,
  output logic           wrap
);

  localparam logic [c_W-1:0] c_ONE       = c_W'(1);
  localparam logic [c_W-1:0] c_ONES      = '1;
  localparam logic [c_W-1:0] c_ZERO      = '0;
  localparam logic [c_W-1:0] c_INIT_GRAY = INITIAL_COUNT ^ (INITIAL_COUNT >> 1);

  logic [c_W-1:0] bin_q;
  logic [c_W-1:0] bin_d;
  logic [c_W-1:0] gray_q;
  logic [c_W-1:0] gray_d;
  logic           wrap_q;
  logic           wrap_d;

  function automatic logic [c_W-1:0] gray2bin(input logic [c_W-1:0] g);
    logic [c_W-1:0] b;
    b = '0;
    b[c_W-1] = g[c_W-1];
    for (int i = c_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (clear) begin
      bin_d = INITIAL_COUNT;
    end else if (load) begin
      bin_d = load_is_gray ? gray2bin(load_value) : load_value;
    end else if (run) begin
      if (up_down) begin
        wrap_d = (bin_q == c_ONES);
`ifdef GRAY_COUNTER_UPDOWN_SATURATE_EN
        if (bin_q != c_ONES) bin_d = bin_q + c_ONE;
`else
        bin_d = bin_q + c_ONE;
`endif
      end else begin
        wrap_d = (bin_q == c_ZERO);
`ifdef GRAY_COUNTER_UPDOWN_SATURATE_EN
        if (bin_q != c_ZERO) bin_d = bin_q - c_ONE;
`else
        bin_d = bin_q - c_ONE;
`endif
      end
    end
  end

  // Gray register is loaded from the next binary value so both outputs move on the same edge.
  assign gray_d = bin_d ^ (bin_d >> 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bin_q  <= INITIAL_COUNT;
      gray_q <= c_INIT_GRAY;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign gray_out   = gray_q;
  assign binary_out = bin_q;
  assign wrap       = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_gray_counter_updown.sv
// ============================================================================
// Module   : tb_gray_counter_updown
// Brief    : Directed self-checking bench for gray_counter_updown (width 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_counter_updown;

  logic       clock;
  logic       reset;
  logic       clear;
  logic       load;
  logic       load_is_gray;
  logic [3:0] load_value;
  logic       run;
  logic       up_down;
  logic [3:0] gray_a, bin_a, gray_b, bin_b;
  logic       wrap_a, wrap_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] gseq [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                            4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
  logic [3:0] prev;

  gray_counter_updown #(.WORD_WIDTH(4), .INITIAL_COUNT(4'd5)) dut_a (
    .clock(clock), .reset(reset), .clear(clear), .load(load),
    .load_is_gray(load_is_gray), .load_value(load_value), .run(run),
    .up_down(up_down), .gray_out(gray_a), .binary_out(bin_a), .wrap(wrap_a)
  );

  gray_counter_updown #(.WORD_WIDTH(4), .INITIAL_COUNT(4'd2)) dut_b (
    .clock(clock), .reset(reset), .clear(clear), .load(load),
    .load_is_gray(load_is_gray), .load_value(load_value), .run(run),
    .up_down(up_down), .gray_out(gray_b), .binary_out(bin_b), .wrap(wrap_b)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; load = 1'b0; load_is_gray = 1'b0;
    load_value = 4'h0; run = 1'b0; up_down = 1'b1;

    #1;
    check_val("rst_bin", bin_a, 4'b0101);
    check_val("rst_gray", gray_a, 4'b0111);
    check_val("rst_wrap", wrap_a, 1'b0);
    check_val("rst_bin_b", bin_b, 4'b0010);

    tick();
    reset = 1'b0;
    #1;
    check_val("rel_bin", bin_a, 4'b0101);
    check_val("rel_gray", gray_a, 4'b0111);
    tick();
    check_val("hold_bin", bin_a, 4'b0101);
    check_val("hold_wrap", wrap_a, 1'b0);

    // Count up through a full cycle starting at zero
    load = 1'b1; load_value = 4'h0;
    tick();
    check_val("ld0_gray", gray_a, 4'h0);
    load = 1'b0; run = 1'b1; up_down = 1'b1;
    prev = gray_a;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check_val("up_gray", gray_a, gseq[k % 16]);
      check_val("up_ham", $countones(prev ^ gray_a), 1);
      check_val("up_wrap", wrap_a, (k == 16));
      prev = gray_a;
    end

    // Gray load beats run in the same cycle
    load = 1'b1; load_is_gray = 1'b1; load_value = 4'b1101; run = 1'b1;
    tick();
    check_val("ldg_bin", bin_a, 4'b1001);
    check_val("ldg_gray", gray_a, 4'b1101);
    check_val("ldg_wrap", wrap_a, 1'b0);

    // Down from zero, then immediately reverse
    load_is_gray = 1'b0; load_value = 4'h0; run = 1'b0;
    tick();
    load = 1'b0; run = 1'b1; up_down = 1'b0;
    tick();
`ifdef GRAY_COUNTER_UPDOWN_SATURATE_EN
    check_val("dn_bin", bin_a, 4'b0000);
    check_val("dn_gray", gray_a, 4'b0000);
    check_val("dn_wrap", wrap_a, 1'b1);
    up_down = 1'b1;
    tick();
    check_val("rev_bin", bin_a, 4'b0001);
    check_val("rev_wrap", wrap_a, 1'b0);
`else
    check_val("dn_bin", bin_a, 4'b1111);
    check_val("dn_gray", gray_a, 4'b1000);
    check_val("dn_wrap", wrap_a, 1'b1);
    up_down = 1'b1;
    tick();
    check_val("rev_bin", bin_a, 4'b0000);
    check_val("rev_wrap", wrap_a, 1'b1);
`endif
    run = 1'b0;
    tick();
    check_val("idle_wrap", wrap_a, 1'b0);

    // Clear wins over load
    load = 1'b1; load_value = 4'd7;
    tick();
    check_val("ld7_bin", bin_a, 4'd7);
    check_val("ld7_gray", gray_a, 4'b0100);
    clear = 1'b1; load_value = 4'hA;
    tick();
    check_val("clr_bin_b", bin_b, 4'b0010);
    check_val("clr_gray_b", gray_b, 4'b0011);
    check_val("clr_bin_a", bin_a, 4'b0101);
    check_val("clr_gray_a", gray_a, 4'b0111);
    check_val("clr_wrap", wrap_b, 1'b0);
    clear = 1'b0;

    // Run up from all-ones for three cycles
    load_value = 4'hF;
    tick();
    load = 1'b0; run = 1'b1; up_down = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
`ifdef GRAY_COUNTER_UPDOWN_SATURATE_EN
      check_val("sat_bin", bin_a, 4'hF);
      check_val("sat_wrap", wrap_a, 1'b1);
`else
      check_val("top_bin", bin_a, j);
      check_val("top_wrap", wrap_a, (j == 0));
`endif
    end
    run = 1'b0;

    // Asynchronous reset while wrap is high
    load = 1'b1; load_value = 4'hF;
    tick();
    load = 1'b0; run = 1'b1;
    tick();
    check_val("pre_wrap", wrap_a, 1'b1);
    run = 1'b0;
    reset = 1'b1;
    #2;
    check_val("arst_bin", bin_a, 4'b0101);
    check_val("arst_gray", gray_a, 4'b0111);
    check_val("arst_wrap", wrap_a, 1'b0);
    check_val("arst_bin_b", bin_b, 4'b0010);
    tick();
    reset = 1'b0;
    tick();
    check_val("post_bin", bin_a, 4'b0101);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
